sbinit_fsm: RTL and testbench

- SBINIT sub-state sequencer for the link training state machine; sits directly downstream of LTSM_top, which starts it on entry to SBINIT and consumes done/error to choose the next LT state.
- Drives the sideband TX message/pattern interface and consumes sideband RX messages and pattern detection.
- Sequence: clock pattern exchange, Out-of-Reset message exchange, then SBINIT done request/response handshake.

---
 rtl/sbinit_fsm.sv | 143 ++++++++++++++
 tb/tb_sbinit_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sbinit_fsm.sv
// SBINIT sub-state sequencer: clock pattern exchange, Out-of-Reset exchange,
// then the SBINIT done request/response handshake over the sideband.
module sbinit_fsm #(
    parameter int          TIMEOUT_CYCLES   = 800000,
    parameter int          PAT_EXTRA_CYCLES = 4,
    parameter logic [7:0]  OOR_CODE         = 8'h91,
    parameter logic [7:0]  DONE_REQ_CODE    = 8'h95,
    parameter logic [7:0]  DONE_RESP_CODE   = 8'h9A
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        start_i,
    output logic        done_o,
    output logic        error_o,
    output logic        tx_pattern_en_o,
    input  logic        rx_pattern_det_i,
    output logic [63:0] tx_msg_o,
    output logic        tx_valid_o,
    input  logic        tx_ack_i,
    input  logic [63:0] rx_msg_i,
    input  logic        rx_valid_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int HW = $clog2(PAT_EXTRA_CYCLES + 1) + 1;
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(PAT_EXTRA_CYCLES);

    typedef enum logic [2:0] {
        IDLE, PATTERN, PAT_HOLD, OOR, DONE_XCHG, DONE, ERROR
    } state_t;

    state_t        state;
    logic [CW-1:0] to_cnt;
    logic [HW-1:0] hold_cnt;
    logic          oor_rx, oor_acked, req_sent, resp_pending, sent_resp, got_resp;

    logic [7:0] rx_code;
    logic       unused_rx;
    logic       rx_oor, rx_req, rx_resp, acked, in_xchg_window;

    assign rx_code   = rx_msg_i[7:0];
    assign unused_rx = ^rx_msg_i[63:8];
    assign rx_oor    = rx_valid_i && (rx_code == OOR_CODE);
    assign rx_req    = rx_valid_i && (rx_code == DONE_REQ_CODE);
    assign rx_resp   = rx_valid_i && (rx_code == DONE_RESP_CODE);
    assign acked     = tx_valid_o && tx_ack_i;
    // Partner may run ahead into its done handshake while we still sit in OOR.
    assign in_xchg_window = (state == OOR) || (state == DONE_XCHG);

    always_ff @(posedge clk_100MHz) begin
        if (!reset || (state != IDLE && !start_i)) begin
            state           <= IDLE;
            done_o          <= 1'b0;
            error_o         <= 1'b0;
            tx_pattern_en_o <= 1'b0;
            tx_msg_o        <= '0;
            tx_valid_o      <= 1'b0;
            to_cnt          <= '0;
            hold_cnt        <= '0;
            oor_rx          <= 1'b0;
            oor_acked       <= 1'b0;
            req_sent        <= 1'b0;
            resp_pending    <= 1'b0;
            sent_resp       <= 1'b0;
            got_resp        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state           <= PATTERN;
                        tx_pattern_en_o <= 1'b1;
                        to_cnt          <= '0;
                    end
                end
                DONE, ERROR: ;
                default: begin
                    if (to_cnt == TO_LAST) begin
                        state           <= ERROR;
                        error_o         <= 1'b1;
                        tx_valid_o      <= 1'b0;
                        tx_pattern_en_o <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (acked) begin
                            tx_valid_o <= 1'b0;
                            if (tx_msg_o[7:0] == OOR_CODE)       oor_acked <= 1'b1;
                            if (tx_msg_o[7:0] == DONE_REQ_CODE)  req_sent  <= 1'b1;
                            if (tx_msg_o[7:0] == DONE_RESP_CODE) sent_resp <= 1'b1;
                        end
                        if (rx_oor && state != DONE_XCHG) oor_rx <= 1'b1;
                        if (rx_resp && in_xchg_window)    got_resp <= 1'b1;

                        // New messages only launch from a low tx_valid_o, which
                        // guarantees the one-cycle gap after every ack.
                        case (state)
                            PATTERN: begin
                                if (rx_pattern_det_i) begin
                                    state    <= PAT_HOLD;
                                    hold_cnt <= HOLD_INIT;
                                end
                            end
                            PAT_HOLD: begin
                                if (hold_cnt <= HW'(1)) begin
                                    state           <= OOR;
                                    tx_pattern_en_o <= 1'b0;
                                end else begin
                                    hold_cnt <= hold_cnt - 1'b1;
                                end
                            end
                            OOR: begin
                                if (oor_rx && oor_acked && !tx_valid_o) begin
                                    state <= DONE_XCHG;
                                end else if (!tx_valid_o) begin
                                    tx_valid_o <= 1'b1;
                                    tx_msg_o   <= {56'd0, OOR_CODE};
                                end
                            end
                            DONE_XCHG: begin
                                if (req_sent && sent_resp && got_resp && !tx_valid_o) begin
                                    state  <= DONE;
                                    done_o <= 1'b1;
                                end else if (!tx_valid_o) begin
                                    if (resp_pending) begin
                                        tx_valid_o   <= 1'b1;
                                        tx_msg_o     <= {56'd0, DONE_RESP_CODE};
                                        resp_pending <= 1'b0;
                                    end else if (!req_sent) begin
                                        tx_valid_o <= 1'b1;
                                        tx_msg_o   <= {56'd0, DONE_REQ_CODE};
                                    end
                                end
                            end
                            default: ;
                        endcase
                        // Placed after the launch so a request arriving as a
                        // response launches still queues another response.
                        if (rx_req && in_xchg_window) resp_pending <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sbinit_fsm.sv
// Directed bench for sbinit_fsm: nominal vector table plus hand-written
// sequences for early request, abort, reset and timeout.
module tb_sbinit_fsm;
    logic        clk;
    logic        reset;
    logic        start;
    logic        done;
    logic        error;
    logic        pat_en;
    logic        det;
    logic [63:0] tx_msg;
    logic        tx_valid;
    logic        tx_ack;
    logic [63:0] rx_msg;
    logic        rx_valid;

    int checks = 0;
    int errors = 0;

    sbinit_fsm #(.TIMEOUT_CYCLES(100), .PAT_EXTRA_CYCLES(4)) dut (
        .clk_100MHz       (clk),
        .reset            (reset),
        .start_i          (start),
        .done_o           (done),
        .error_o          (error),
        .tx_pattern_en_o  (pat_en),
        .rx_pattern_det_i (det),
        .tx_msg_o         (tx_msg),
        .tx_valid_o       (tx_valid),
        .tx_ack_i         (tx_ack),
        .rx_msg_i         (rx_msg),
        .rx_valid_i       (rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start, det, ack, rv;
        logic [7:0] code;
        logic       pat, vld;
        logic [7:0] ecode;
        logic       done, err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic d, logic a, logic r, logic [7:0] c,
                                logic p, logic v, logic [7:0] ec, logic dn, logic er);
        vec_t t;
        t.start = s; t.det = d; t.ack = a; t.rv = r; t.code = c;
        t.pat = p; t.vld = v; t.ecode = ec; t.done = dn; t.err = er;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input logic v, input logic [7:0] c);
        rx_valid = v;
        rx_msg   = {56'hA5A5A5A5A5A5A5, c};
    endtask

    task automatic pulse_rx(input logic [7:0] c);
        set_rx(1'b1, c);
        tick();
        set_rx(1'b0, 8'h00);
    endtask

    task automatic ack_tx();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
    endtask

    // Bounded wait for tx_valid, then check the launched message.
    task automatic wait_valid(input logic [7:0] code, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (tx_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no tx_valid expected code %0h", name, code);
        end else begin
            chk(name, tx_msg, {56'd0, code});
        end
    endtask

    function automatic logic [3:0] outs();
        return {pat_en, tx_valid, done, error};
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; det = 1'b0; tx_ack = 1'b0;
        set_rx(1'b0, 8'h00);
        tick(); tick();
        chk("reset_outs", {60'd0, outs()}, 64'd0);
        chk("reset_msg", tx_msg, 64'd0);
        reset = 1'b1;

        // Nominal sequence, one row per clock edge.
        tbl.push_back(mk(1,0,0,0,8'h00, 1,0,8'h00,0,0));
        for (int i = 2; i <= 9; i++) tbl.push_back(mk(1,0,0,0,8'h00, 1,0,8'h00,0,0));
        tbl.push_back(mk(1,1,0,0,8'h00, 1,0,8'h00,0,0));
        for (int i = 11; i <= 13; i++) tbl.push_back(mk(1,0,0,0,8'h00, 1,0,8'h00,0,0));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,0,8'h00,0,0));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,8'h91,0,0));
        tbl.push_back(mk(1,0,0,1,8'h91, 0,1,8'h91,0,0));
        tbl.push_back(mk(1,0,1,0,8'h00, 0,0,8'h00,0,0));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,0,8'h00,0,0));
        tbl.push_back(mk(1,0,0,1,8'h95, 0,1,8'h95,0,0));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,8'h95,0,0));
        tbl.push_back(mk(1,0,1,0,8'h00, 0,0,8'h00,0,0));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,1,8'h9A,0,0));
        tbl.push_back(mk(1,0,0,1,8'h9A, 0,1,8'h9A,0,0));
        tbl.push_back(mk(1,0,1,0,8'h00, 0,0,8'h00,0,0));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,0,8'h00,1,0));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,0,8'h00,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,0,8'h00,0,0));

        foreach (tbl[i]) begin
            start = tbl[i].start; det = tbl[i].det; tx_ack = tbl[i].ack;
            set_rx(tbl[i].rv, tbl[i].code);
            tick();
            chk($sformatf("nom_row%0d", i + 1), {60'd0, outs()},
                {60'd0, tbl[i].pat, tbl[i].vld, tbl[i].done, tbl[i].err});
            if (tbl[i].vld) chk($sformatf("nom_msg%0d", i + 1), tx_msg, {56'd0, tbl[i].ecode});
        end
        det = 1'b0; tx_ack = 1'b0; set_rx(1'b0, 8'h00);

        // Early partner DONE_REQ, garbage code, rx OOR coincident with ack.
        start = 1'b1; tick();
        det = 1'b1; tick(); det = 1'b0;
        wait_valid(8'h91, "early_oor");
        pulse_rx(8'h00);
        pulse_rx(8'h95);
        tx_ack = 1'b1; set_rx(1'b1, 8'h91); tick();
        tx_ack = 1'b0; set_rx(1'b0, 8'h00);
        chk("simul_ack_vld", {63'd0, tx_valid}, 64'd0);
        wait_valid(8'h9A, "early_resp_first");
        ack_tx();
        wait_valid(8'h95, "early_req_second");
        ack_tx();
        tick();
        chk("early_no_done", {62'd0, done, error}, 64'd0);
        pulse_rx(8'h9A);
        tick();
        chk("early_done", {62'd0, done, error}, 64'd2);
        start = 1'b0; tick();

        // Abort while an OOR is in flight, then restart from PATTERN.
        start = 1'b1; tick();
        det = 1'b1; tick(); det = 1'b0;
        wait_valid(8'h91, "abort_pre");
        start = 1'b0; tick();
        chk("abort_outs", {60'd0, outs()}, 64'd0);
        chk("abort_msg", tx_msg, 64'd0);
        start = 1'b1; tick();
        chk("restart_pat", {60'd0, outs()}, 64'h8);
        tick(); tick();
        chk("restart_no_tx", {63'd0, tx_valid}, 64'd0);
        det = 1'b1; tick(); det = 1'b0;
        wait_valid(8'h91, "restart_oor");
        start = 1'b0; tick();

        // Synchronous reset in DONE_XCHG; a reset pulse between edges is ignored.
        start = 1'b1; tick();
        det = 1'b1; tick(); det = 1'b0;
        wait_valid(8'h91, "rst_oor");
        tx_ack = 1'b1; set_rx(1'b1, 8'h91); tick();
        tx_ack = 1'b0; set_rx(1'b0, 8'h00);
        wait_valid(8'h95, "rst_req");
        reset = 1'b0; #2;
        reset = 1'b1;
        #1;
        chk("rst_no_edge", {63'd0, tx_valid}, 64'd1);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("rst_outs", {60'd0, outs()}, 64'd0);
        chk("rst_msg", tx_msg, 64'd0);
        start = 1'b0; tick();

        // Timeout with no pattern detect.
        start = 1'b1; tick();
        for (int i = 1; i <= 99; i++) tick();
        chk("to_not_yet", {63'd0, error}, 64'd0);
        tick();
        chk("to_err", {62'd0, done, error}, 64'd1);
        tick();
        chk("to_forced", {60'd0, outs()}, 64'd1);
        start = 1'b0; tick();
        chk("to_clear", {60'd0, outs()}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
